// File: rtl/register_file_if.sv
// Register-file port bundle: read/debug indices and data plus the write-back port.
// The master side drives indices and write-back; the slave side is the register file.
interface register_file_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic [ADDR_W-1:0] Read_register_1;
    logic [ADDR_W-1:0] Read_register_2;
    logic [ADDR_W-1:0] Write_register;
    logic [DATA_W-1:0] Write_data;
    logic              RegWrite;
    logic [ADDR_W-1:0] Debug_register;
    logic [DATA_W-1:0] Read_data_1;
    logic [DATA_W-1:0] Read_data_2;
    logic [DATA_W-1:0] Debug_data;

    modport master (
        output Read_register_1, Read_register_2, Write_register,
               Write_data, RegWrite, Debug_register,
        input  Read_data_1, Read_data_2, Debug_data
    );

    modport slave (
        input  Read_register_1, Read_register_2, Write_register,
               Write_data, RegWrite, Debug_register,
        output Read_data_1, Read_data_2, Debug_data
    );
endinterface

// File: rtl/register_file.sv
// Multicycle MIPS register file: 2**ADDR_W x DATA_W, two combinational read ports,
// one combinational debug port, one synchronous write port, register 0 hardwired to zero.
module register_file #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter bit          BYPASS = 1'b0
) (
    input logic            clk,
    input logic            rst_n,
    register_file_if.slave rf
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [ADDR_W-1:0] wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic              we_hit;

    assign wr_idx  = rf.Write_register;
    assign wr_data = rf.Write_data;
    assign we_hit  = rst_n && rf.RegWrite && (wr_idx != '0);

    always_comb begin
        regs_d = regs_q;
        if (we_hit) begin
            regs_d[wr_idx] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Index 0 is forced to zero on every port, ahead of any forwarding.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] idx);
        if (idx == '0) begin
            return '0;
        end
        if (BYPASS && we_hit && (idx == wr_idx)) begin
            return wr_data;
        end
        return regs_q[idx];
    endfunction

    always_comb begin
        rf.Read_data_1 = read_port(rf.Read_register_1);
        rf.Read_data_2 = read_port(rf.Read_register_2);
        rf.Debug_data  = read_port(rf.Debug_register);
    end
endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench: identical stimulus to a BYPASS=0 and a BYPASS=1 instance, checked
// against an array reference model; a Register_A flop checks one-edge capture of port 1.
module tb_register_file;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    register_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if0 ();
    register_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if1 ();

    register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .rf(if0)
    );
    register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .rf(if1)
    );

    // Operand latch downstream of port 1
    logic [31:0] reg_a;
    always @(posedge clk) reg_a <= if0.Read_data_1;

    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            assert (!$isunknown(if0.RegWrite)) else $error("FAIL regwrite_x RegWrite is X while out of reset");
        end
    end

    typedef struct {
        string       tag;
        logic [31:0] e1_0, e2_0, ed_0;
        logic [31:0] e1_1, e2_1, ed_1;
        logic [31:0] ea;
        bit          ea_valid;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] prev_e1;
    bit          prev_valid = 1'b0;
    int          checks = 0;
    int          failures = 0;

    // What a read of idx shows during a cycle with the given write-side inputs
    function automatic logic [31:0] model_read(input logic [4:0] idx, input bit byp,
                                               input bit rst, input bit we,
                                               input logic [4:0] wr, input logic [31:0] wd);
        if (idx == 5'd0) return 32'h0;
        if (byp && rst && we && wr != 5'd0 && idx == wr) return wd;
        return ref_mem[idx];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic cycle(input bit rst, input bit we, input logic [4:0] wr, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dbg,
                         input string tag);
        exp_t it;
        @(posedge clk);
        #1;
        rst_n = rst;
        if0.RegWrite = we;       if1.RegWrite = we;
        if0.Write_register = wr; if1.Write_register = wr;
        if0.Write_data = wd;     if1.Write_data = wd;
        if0.Read_register_1 = r1; if1.Read_register_1 = r1;
        if0.Read_register_2 = r2; if1.Read_register_2 = r2;
        if0.Debug_register = dbg; if1.Debug_register = dbg;
        it.tag  = tag;
        it.e1_0 = model_read(r1, 1'b0, rst, we, wr, wd);
        it.e2_0 = model_read(r2, 1'b0, rst, we, wr, wd);
        it.ed_0 = model_read(dbg, 1'b0, rst, we, wr, wd);
        it.e1_1 = model_read(r1, 1'b1, rst, we, wr, wd);
        it.e2_1 = model_read(r2, 1'b1, rst, we, wr, wd);
        it.ed_1 = model_read(dbg, 1'b1, rst, we, wr, wd);
        it.ea = prev_e1;
        it.ea_valid = prev_valid;
        prev_e1 = it.e1_0;
        prev_valid = 1'b1;
        sb_q.push_back(it);
        // State as it will be after the coming edge
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        end else if (we && wr != 5'd0) begin
            ref_mem[wr] = wd;
        end
    endtask

    initial begin : monitor
        exp_t it;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                it = sb_q.pop_front();
                check({it.tag, ".rd1_b0"}, if0.Read_data_1, it.e1_0);
                check({it.tag, ".rd2_b0"}, if0.Read_data_2, it.e2_0);
                check({it.tag, ".dbg_b0"}, if0.Debug_data,  it.ed_0);
                check({it.tag, ".rd1_b1"}, if1.Read_data_1, it.e1_1);
                check({it.tag, ".rd2_b1"}, if1.Read_data_2, it.e2_1);
                check({it.tag, ".dbg_b1"}, if1.Debug_data,  it.ed_1);
                if (it.ea_valid) check({it.tag, ".reg_a"}, reg_a, it.ea);
            end
        end
    end

    initial begin : stimulus
        logic [4:0]  wr, r1, r2, dbg;
        logic [31:0] wd;
        bit          rst, we;
        rst_n = 1'b0;
        if0.RegWrite = 1'b0; if1.RegWrite = 1'b0;
        if0.Write_register = '0; if1.Write_register = '0;
        if0.Write_data = '0; if1.Write_data = '0;
        if0.Read_register_1 = '0; if1.Read_register_1 = '0;
        if0.Read_register_2 = '0; if1.Read_register_2 = '0;
        if0.Debug_register = '0; if1.Debug_register = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;

        cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0, "rst0");
        cycle(1'b0, 1'b1, 5'd7, 32'h1111, 5'd0, 5'd0, 5'd0, "rst1");

        // Reset clears a preloaded entry
        cycle(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 5'd5, "preload");
        cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5, "r5_set");
        cycle(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 5'd5, "rst_edge");
        cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd0, "rst_after");
        for (int i = 0; i < DEPTH; i++)
            cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'(i), 5'(i), "sweep");

        // Back-to-back writes
        cycle(1'b1, 1'b1, 5'd8, 32'h12345678, 5'd8, 5'd9, 5'd8, "w_r8");
        cycle(1'b1, 1'b1, 5'd9, 32'hFFFF0000, 5'd8, 5'd9, 5'd9, "w_r9");
        cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd8, 5'd9, 5'd9, "r8r9");

        // Register zero
        cycle(1'b1, 1'b1, 5'd0, 32'hAAAAAAAA, 5'd0, 5'd0, 5'd0, "zero_w");
        cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0, "zero_after");

        // Same-cycle read of the write target
        cycle(1'b1, 1'b1, 5'd3, 32'h1, 5'd0, 5'd0, 5'd0, "byp_old");
        cycle(1'b1, 1'b1, 5'd3, 32'h2, 5'd3, 5'd3, 5'd3, "byp_new");
        cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 5'd3, "byp_after");

        // Reset beats a colliding write
        cycle(1'b1, 1'b1, 5'd4, 32'h77, 5'd4, 5'd0, 5'd4, "coll_pre");
        cycle(1'b0, 1'b1, 5'd4, 32'h55, 5'd4, 5'd4, 5'd4, "coll_rst");
        cycle(1'b1, 1'b1, 5'd4, 32'h55, 5'd4, 5'd4, 5'd4, "coll_wr");
        cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd4, 5'd4, 5'd4, "coll_after");

        for (int n = 0; n < 10000; n++) begin
            rst = ($urandom_range(0, 63) != 0);
            we  = $urandom_range(0, 1) == 1;
            wr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            wd  = $urandom;
            r1  = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            r2  = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 31));
            dbg = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            cycle(rst, we, wr, wd, r1, r2, dbg, "rand");
        end

        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
